sar_search_ctrl: RTL and testbench

- Sequential successive-approximation controller that works with the 4-bit magnitude comparator in the other direction: it drives the comparator's B operand and consumes its gt/lt/eq flags.
- It recovers the unknown value on the comparator's A operand by MSB-first binary search.
- It sits next to a combinational comparator instance: trial drives B, and the comparator outputs feed back into cmp_gt/cmp_lt/cmp_eq in the same cycle.

---
 rtl/sar_search_ctrl_if.sv | 26 ++
 rtl/sar_search_ctrl.sv | 103 ++++++++++
 tb/tb_sar_search_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// Bus bundle between the SAR search controller and its neighbouring comparator.
// The slave modport is the controller side; the master modport is the
// comparator / requester side.
interface sar_search_ctrl_if #(
   parameter int unsigned W = 4
);
   logic          start;
   logic          cmp_gt;
   logic          cmp_lt;
   logic          cmp_eq;
   logic [W-1:0]  trial;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cmp_err;

   modport master (
      output start, cmp_gt, cmp_lt, cmp_eq,
      input  trial, busy, done, result, cmp_err
   );

   modport slave (
      input  start, cmp_gt, cmp_lt, cmp_eq,
      output trial, busy, done, result, cmp_err
   );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller: drives the comparator B operand with
// MSB-first trial values and rebuilds the unknown A operand from gt/lt/eq.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as a clean eq is seen.
module sar_search_ctrl #(
   parameter int unsigned W = 4
) (
   input  logic               clk,
   input  logic               rst,
   sar_search_ctrl_if.slave   bus
);
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TEST = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    result_q, result_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            err_q, err_d;

   logic [W-1:0]    trial_c;
   logic [1:0]      flag_cnt_c;
   logic            decide_c;

   // Trial value: the bit under test on top of the bits already decided.
   always_comb begin
      trial_c = result_q;
      if (state_q == S_TEST) begin
         trial_c = result_q | (W'(1) << idx_q);
      end
   end

   // Next-state and datapath update for the search sequence.
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      idx_d      = idx_q;
      err_d      = err_q;
      flag_cnt_c = 2'(bus.cmp_gt) + 2'(bus.cmp_lt) + 2'(bus.cmp_eq);
      decide_c   = bus.cmp_gt | bus.cmp_eq;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_TEST;
               result_d = '0;
               idx_d    = IW'(W - 1);
               err_d    = 1'b0;
            end
         end
         S_TEST: begin
            // Malformed flags are flagged but the search still runs to the end.
            if (flag_cnt_c != 2'd1) begin
               err_d = 1'b1;
            end
            result_d[idx_q] = decide_c;
            if (idx_q == '0) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
`ifdef SAR_EARLY_EXIT_EN
            // A clean exact match means every lower bit is already known.
            if (bus.cmp_eq && !bus.cmp_gt && !bus.cmp_lt) begin
               result_d = trial_c;
               state_d  = S_DONE;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any search in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         idx_q    <= IW'(W - 1);
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
      end
   end

   assign bus.trial   = trial_c;
   assign bus.busy    = (state_q == S_TEST);
   assign bus.done    = (state_q == S_DONE);
   assign bus.result  = result_q;
   assign bus.cmp_err = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: behavioural comparator, table of directed
// searches, hand-written corner sequences and randomized searches with
// optional flag corruption checked against a reference search model.
module tb_sar_search_ctrl;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sar_search_ctrl_if #(.W(W)) bus ();

   sar_search_ctrl #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Comparator model with an override path to inject malformed flags.
   logic [W-1:0] a_val;
   logic         fen, fg, fl, fe;

   always_comb begin
      if (fen) begin
         bus.cmp_gt = fg;
         bus.cmp_lt = fl;
         bus.cmp_eq = fe;
      end else begin
         bus.cmp_gt = (a_val > bus.trial);
         bus.cmp_lt = (a_val < bus.trial);
         bus.cmp_eq = (a_val == bus.trial);
      end
   end

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] m_trials [W];
   int           m_n;
   logic [W-1:0] m_res;
   logic         m_err;

   typedef struct {
      logic [W-1:0] a;
      int           inj;
      logic [2:0]   f;        // {gt, lt, eq} forced in step inj (0 = none)
      logic [W-1:0] exp_res;
      logic         exp_err;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference binary search: step s tests bit W-s on top of the bits kept so far.
   task automatic model(input logic [W-1:0] a, input int inj, input logic ig, input logic il,
                        input logic ie);
      logic [W-1:0] r, t;
      logic g, l, e;
      r     = '0;
      m_err = 1'b0;
      m_n   = 0;
      for (int s = 1; s <= int'(W); s++) begin
         t = r | (W'(1) << (int'(W) - s));
         m_trials[s-1] = t;
         m_n = s;
         if (s == inj) begin
            g = ig; l = il; e = ie;
         end else begin
            g = (a > t); l = (a < t); e = (a == t);
         end
         if ((int'(g) + int'(l) + int'(e)) != 1) m_err = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
         if (e && !g && !l) begin
            r = t;
            break;
         end
`endif
         if (g || e) r = t;
      end
      m_res = r;
   endtask

   task automatic run_search(input logic [W-1:0] a, input int inj, input logic ig,
                             input logic il, input logic ie,
                             output logic [W-1:0] res_o, output logic err_o);
      model(a, inj, ig, il, ie);
      a_val = a;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int k = 1; k <= m_n; k++) begin
         @(negedge clk);
         chk("busy_in_test", 32'(bus.busy), 32'd1);
         chk("trial_seq", 32'(bus.trial), 32'(m_trials[k-1]));
         chk("done_low_in_test", 32'(bus.done), 32'd0);
         if (k == 1) chk("err_cleared_on_start", 32'(bus.cmp_err), 32'd0);
         if (k == inj) begin
            fg = ig; fl = il; fe = ie; fen = 1'b1;
         end
         @(posedge clk);
         #1 fen = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("busy_in_done", 32'(bus.busy), 32'd0);
      chk("result_model", 32'(bus.result), 32'(m_res));
      chk("err_model", 32'(bus.cmp_err), 32'(m_err));
      chk("trial_in_done", 32'(bus.trial), 32'(m_res));
      res_o = bus.result;
      err_o = bus.cmp_err;
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("result_held", 32'(bus.result), 32'(m_res));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] r, a;
      logic         e;
      int           inj, last, pulses;
      logic [2:0]   f;

      tbl[0] = '{4'b1011, 0, 3'b000, 4'b1011, 1'b0};
      tbl[1] = '{4'b0000, 0, 3'b000, 4'b0000, 1'b0};
      tbl[2] = '{4'b1111, 0, 3'b000, 4'b1111, 1'b0};
      tbl[3] = '{4'b0110, 2, 3'b110, 4'b0110, 1'b1};
      tbl[4] = '{4'b0110, 0, 3'b000, 4'b0110, 1'b0};
      tbl[5] = '{4'b1011, 1, 3'b000, 4'b0111, 1'b1};
      tbl[6] = '{4'b1000, 0, 3'b000, 4'b1000, 1'b0};
      tbl[7] = '{4'b0001, 0, 3'b000, 4'b0001, 1'b0};
      tbl[8] = '{4'b0110, 3, 3'b001, 4'b0110, 1'b0};

      rst = 1'b1; bus.start = 1'b0; a_val = '0;
      fen = 1'b0; fg = 1'b0; fl = 1'b0; fe = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_trial", 32'(bus.trial), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_err", 32'(bus.cmp_err), 32'd0);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         run_search(tbl[i].a, tbl[i].inj, tbl[i].f[2], tbl[i].f[1], tbl[i].f[0], r, e);
         chk("tbl_result", 32'(r), 32'(tbl[i].exp_res));
         chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
      end

      // Sticky error survives IDLE, next clean search clears it.
      run_search(4'b0110, 2, 1'b1, 1'b1, 1'b0, r, e);
      repeat (3) @(negedge clk);
      chk("err_sticky_idle", 32'(bus.cmp_err), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_trial_is_result", 32'(bus.trial), 32'h6);
      run_search(4'b0110, 0, 1'b0, 1'b0, 1'b0, r, e);
      chk("rerun_err", 32'(e), 32'd0);

      // Start held high: one accepted search every W+2 cycles.
      a_val = 4'b0101;
      @(negedge clk);
      bus.start = 1'b1;
      last = -1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            pulses++;
            chk("cont_result", 32'(bus.result), 32'h5);
            if (last >= 0) chk("cont_period", 32'(c - last), 32'(W + 2));
            last = c;
         end
      end
      bus.start = 1'b0;
      chk("cont_pulses", 32'(pulses), 32'd6);
      repeat (8) @(negedge clk);

      // Asynchronous reset in the middle of a search.
      a_val = 4'b1001;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1 chk("pre_reset_trial", 32'(bus.trial), 32'hC);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_trial", 32'(bus.trial), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_done", 32'(bus.done), 32'd0);
      chk("async_rst_result", 32'(bus.result), 32'd0);
      chk("async_rst_err", 32'(bus.cmp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(bus.done), 32'd0);
         chk("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      // Randomized searches, occasionally with corrupted flags.
      for (int i = 0; i < 30; i++) begin
         a   = W'($urandom);
         inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
         f   = 3'($urandom_range(0, 7));
         run_search(a, inj, f[2], f[1], f[0], r, e);
         if (inj == 0) begin
            chk("rand_result_is_a", 32'(r), 32'(a));
            chk("rand_no_err", 32'(e), 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
